// File: rtl/gost_28147_89_mac.sv
// gost_28147_89_mac
//   GOST 28147-89 imitovstavka (MAC) generator with optional tag verifier.
//   Each accepted 64-bit block is XORed into the accumulator {b,a} and then
//   run through 16 rounds, one per clock. The key schedule is K0..K7 twice,
//   and there is no final swap. On the last block the low MAC_W bits of the
//   round-16 result are registered as the tag.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key[255:0] cipher key, K0 = key[255:224] ... K7 = key[31:0]
//   start      begin a new message; clears the accumulator, mac and mac_ok
//   din_valid  message block offered
//   din[63:0]  message block: [63:32] goes into b, [31:0] goes into a
//   last       marks the accepted block as the final one
//   din_ready  high in IDLE only
//   mac_valid  one-cycle pulse when the tag is complete
//   mac        tag, held until the next start or rst
//   tag_in     received tag to compare against
//   mac_ok     tag match flag, valid with mac_valid and held with mac
//
// Build option
//   GOST_MAC_VERIFY_EN  when defined, mac_ok compares the tag with tag_in.
//                       When undefined, mac_ok is constant 0.
//
// state | meaning
// IDLE  | waiting for a block; din_ready = 1
// ROUND | 16 transform rounds on the accumulator; din_ready = 0

module gost_28147_89_mac #(
  parameter int MAC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     key,
  input  logic             start,
  input  logic             din_valid,
  input  logic [63:0]      din,
  input  logic             last,
  output logic             din_ready,
  output logic             mac_valid,
  output logic [MAC_W-1:0] mac,
  input  logic [MAC_W-1:0] tag_in,
  output logic             mac_ok
);

  typedef enum logic {IDLE, ROUND} state_t;

  // Project S-box table. Row j drives nibble j (row 0 = least significant).
  // Within a row, entry v sits at bits [63-4v -: 4].
  localparam logic [63:0] SBOX_ROW [8] = '{
    64'hC462A5B9E8D703F1,
    64'h68239A5C1E47BD0F,
    64'hB3582FADE174C960,
    64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C,
    64'h5DF692CAB78143E0,
    64'h8E25691CF4B0DA37,
    64'h17ED05834FA69CB2
  };

  function automatic logic [31:0] sbox_sub(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      y[4*j +: 4] = SBOX_ROW[j][{~x[4*j +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] a, b;
  logic [3:0]  i;
  logic        last_q;
  logic        accept;
  logic        tag_done;
  logic [31:0] k_cur, sum, sub, a_new;

  // {~i, 5'b0} = 32*(7-i): selects K0 at the top of the key bus.
  assign k_cur = key[{~i[2:0], 5'b00000} +: 32];
  assign sum   = a + k_cur;
  assign sub   = sbox_sub(sum);
  assign a_new = b ^ {sub[20:0], sub[31:21]};

  assign din_ready = (state_q == IDLE);
  assign accept    = din_valid & din_ready;
  // Abort by start wins over completing round 16.
  assign tag_done  = (state_q == ROUND) & ~start & (i == 4'd15) & last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (start || i == 4'd15) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      i         <= '0;
      last_q    <= 1'b0;
      mac       <= '0;
      mac_valid <= 1'b0;
    end else begin
      mac_valid <= tag_done;
      if (start) mac <= '0;
      if (tag_done) mac <= a_new[MAC_W-1:0];

      if (state_q == IDLE) begin
        if (accept) begin
          // start in the same cycle makes this the first block of a message
          {b, a} <= (start ? 64'd0 : {b, a}) ^ din;
          last_q <= last;
          i      <= '0;
        end else if (start) begin
          {b, a} <= '0;
        end
      end else if (start) begin
        {b, a} <= '0;
        i      <= '0;
      end else begin
        a <= a_new;
        b <= a;
        i <= i + 4'd1;
      end
    end
  end

`ifdef GOST_MAC_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           mac_ok <= 1'b0;
    else if (tag_done) mac_ok <= (a_new[MAC_W-1:0] == tag_in);
    else if (start)    mac_ok <= 1'b0;
  end
`else
  logic unused_tag;
  assign unused_tag = ^tag_in;
  assign mac_ok     = 1'b0;
`endif

endmodule

// File: doc/gost_28147_89_mac.md
# gost_28147_89_mac

GOST 28147-89 imitovstavka (MAC) generator and verifier. It is the receiving and authenticating end of the cipher datapath. It absorbs a stream of 64-bit message blocks, runs the 16-round MAC transform on each block with the shared 256-bit key, and reports a MAC_W-bit tag. When verification is compiled in, it also checks that tag against a received tag. It sits beside the 32-round cipher core, shares its key bus and the project S-box table (`sbox.vh`), and is driven by the same block-level controller.

## Interface
- MAC_W, default 32: tag width, 1..32. Tag = MAC_W LSBs of N1 (register `a`).
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- key  in  256  cipher key. K0 = key[255:224] … K7 = key[31:0]. Must be stable from start to mac_valid.
- start  in  1  begin new message; clears accumulator
- din_valid  in  1  message block offered
- din  in  64  message block; din[63:32] XORs into `b`, din[31:0] into `a`
- last  in  1  qualifies the accepted block as the final one
- din_ready  out  1  block can be accepted (IDLE)
- mac_valid  out  1  one-cycle pulse: tag complete
- mac  out  MAC_W  computed tag, held until next start or rst
- tag_in  in  MAC_W  received tag to check
- mac_ok  out  1  tag match flag, valid with mac_valid, held with mac

## Operation
- States:
  - IDLE: din_ready=1.
  - ROUND: 16 cycles, din_ready=0.
- Accept condition: din_valid & din_ready. On accept: {b,a} <= {b,a} ^ din, latch last, round counter i <= 0, go to ROUND.
- ROUND, each cycle:
  - a <= b ^ rol11(S(a + K[i[2:0]])), where + is modulo 2^32.
  - b <= a.
  - i <= i+1.
  - Key order is K0..K7, K0..K7.
- No final swap after round 16.
- After round 16 (i==15): return to IDLE.
  - If latched last: register mac <= a_new[MAC_W-1:0] and pulse mac_valid.
  - The accumulator is retained; the next message requires start.
- start in IDLE: {b,a} <= 0.
- start with an accept in the same cycle: {b,a} <= din. This is the first block of a new message.
- start in ROUND: abort, {b,a} <= 0, go to IDLE; no mac_valid. Any din_valid that cycle is not accepted because din_ready=0.
- start also clears mac and mac_ok.
- A block accepted without a preceding start chains onto the current accumulator. This is legal and is how multi-block messages work.
- last on a single-block message is legal. An empty message is not supported.

## Timing
- Reset values:
  - din_ready=1, mac_valid=0, mac=0, mac_ok=0.
  - {b,a}=0, i=0, state IDLE.
- Reset mid-ROUND: immediate return to reset values.
- Cycle sequence:
  - Accept at edge E0.
  - Rounds at edges E1..E16.
  - din_ready high again after E16.
  - mac_valid high for exactly the cycle after E16.
- Throughput: one block per 17 cycles. A next block may be accepted in the same cycle mac_valid is high.
- din_ready depends only on state, with no combinational path from inputs.
- mac and mac_ok change only at the E16 edge of a last block, on start, or on rst.

## Configuration
- GOST_MAC_VERIFY_EN:
  - Defined: a comparator registers mac_ok <= (a_new[MAC_W-1:0] == tag_in) at the same edge as mac. tag_in is sampled at that edge.
  - Undefined: tag_in is ignored and mac_ok is constant 0. The port list is unchanged.

## Test plan
- Reset then idle: rst pulse mid-cycle, with no clock required -> din_ready=1, mac_valid=0, mac=0 immediately. After 20 idle cycles, none of them change.
- Single block: key=0x0011…EEFF pattern, start+din_valid+last with din=0x0123456789ABCDEF -> din_ready low for exactly 16 cycles, mac_valid pulse 17 cycles after accept, mac equals the C reference model (MAC_W=32).
- Four-block message: back-to-back blocks, last on the 4th -> accepts exactly 17 cycles apart, a single mac_valid after the 4th block, mac matches the model. A repeat with MAC_W=16 gives the model's low 16 bits.
- Abort: start asserted at round 8 of a block -> no mac_valid. A fresh single-block message then yields the same mac as the single-block case.
- Verify (GOST_MAC_VERIFY_EN defined): tag_in = expected mac -> mac_ok=1 with mac_valid. tag_in = expected ^ 1 -> mac_ok=0. Undefined build -> mac_ok=0 in both cases.
- Async reset during ROUND at round 5 -> all outputs return to reset values at once. The next message produces the correct mac.
